// File: rtl/fp_result_uart_tx_if.sv
// Result-word handshake and UART byte/strobe signals shared by the compute side,
// the serializer and the UART transmitter.
interface fp_result_uart_tx_if;
  logic [31:0] fp_data;
  logic        fp_valid;
  logic        fp_ready;
  logic        uart_tx_done;
  logic [7:0]  uart_tx_data;
  logic        uart_send_data;
  logic        busy;
  logic [15:0] words_sent;
  logic        overflow;

  modport master (
    output fp_data, fp_valid, uart_tx_done,
    input  fp_ready, uart_tx_data, uart_send_data, busy, words_sent, overflow
  );

  modport slave (
    input  fp_data, fp_valid, uart_tx_done,
    output fp_ready, uart_tx_data, uart_send_data, busy, words_sent, overflow
  );
endinterface

// File: rtl/fp_result_uart_tx.sv
// Buffers 32-bit result words in a FIFO and serializes each one as 4 UART bytes,
// pacing every byte on the transmitter's done pulse.
module fp_result_uart_tx #(
  parameter int DEPTH     = 16,
  parameter int MSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               rst,
  fp_result_uart_tx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t         state_q, state_d;
  logic [31:0]    mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [31:0]    shift_q, shift_d;
  logic [1:0]     byte_idx_q, byte_idx_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           send_q, send_d;
  logic [15:0]    words_q, words_d;
  logic           overflow_q, overflow_d;
  logic           full;
  logic           push;
  logic           pop;

  function automatic logic [7:0] lead_byte(input logic [31:0] w);
    return (MSB_FIRST != 0) ? w[31:24] : w[7:0];
  endfunction

  function automatic logic [31:0] drop_byte(input logic [31:0] w);
    return (MSB_FIRST != 0) ? {w[23:0], 8'h00} : {8'h00, w[31:8]};
  endfunction

  // Full blocks the push even when the FSM pops in the same cycle.
  assign full = (count_q == (AW+1)'(DEPTH));
  assign push = bus.fp_valid && !full;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    tx_data_d  = tx_data_q;
    send_d     = 1'b0;
    words_d    = words_q;
    overflow_d = overflow_q | (bus.fp_valid & full);
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          tx_data_d  = lead_byte(mem_q[rd_ptr_q]);
          shift_d    = drop_byte(mem_q[rd_ptr_q]);
          byte_idx_d = 2'd0;
          send_d     = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (bus.uart_tx_done) begin
          if (byte_idx_q == 2'd3) begin
            words_d = words_q + 16'd1;
            state_d = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            tx_data_d  = lead_byte(shift_q);
            shift_d    = drop_byte(shift_q);
            send_d     = 1'b1;
            state_d    = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      tx_data_q  <= '0;
      send_q     <= 1'b0;
      words_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      tx_data_q  <= tx_data_d;
      send_q     <= send_d;
      words_q    <= words_d;
      overflow_q <= overflow_d;
      if (push) mem_q[wr_ptr_q] <= bus.fp_data;
    end
  end

  assign bus.fp_ready       = !full;
  assign bus.uart_tx_data   = tx_data_q;
  assign bus.uart_send_data = send_q;
  assign bus.busy           = (state_q != IDLE) || (count_q != '0);
  assign bus.words_sent     = words_q;
  assign bus.overflow       = overflow_q;
endmodule

// File: tb/tb_fp_result_uart_tx.sv
// Directed bench for fp_result_uart_tx: byte order, latency, FIFO full/overflow,
// spurious done pulses and mid-word reset.
module tb_fp_result_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_result_uart_tx_if bus();
  fp_result_uart_tx_if lbus();

  fp_result_uart_tx #(.DEPTH(16), .MSB_FIRST(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  fp_result_uart_tx #(.DEPTH(16), .MSB_FIRST(0)) dut_lsb (.clk(clk), .rst(rst), .bus(lbus));

  int checks = 0;
  int errors = 0;
  logic [7:0]  cap_q[$];
  logic [7:0]  lcap_q[$];
  logic [31:0] exp_q[$];
  logic resp_en = 1'b0;
  logic resp_done = 1'b0;
  logic spur_done = 1'b0;
  int   resp_cnt = 0;
  logic prev_send = 1'b0;
  logic [2:0] lpipe = 3'b000;

  assign bus.uart_tx_done = resp_done | spur_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte capture, back-to-back strobe check and done responders (all on negedge).
  always @(negedge clk) begin
    if (bus.uart_send_data) begin
      cap_q.push_back(bus.uart_tx_data);
      checks++;
      assert (!prev_send) else begin
        errors++;
        $error("FAIL strobe_consecutive observed=1 expected=0");
      end
    end
    prev_send = bus.uart_send_data;
    resp_done = 1'b0;
    if (rst || !resp_en) resp_cnt = 0;
    else if (bus.uart_send_data) resp_cnt = 5;
    else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) resp_done = 1'b1;
    end
    if (lbus.uart_send_data) lcap_q.push_back(lbus.uart_tx_data);
    lpipe = {lpipe[1:0], lbus.uart_send_data};
    lbus.uart_tx_done = lpipe[2];
  end

  task automatic push(input logic [31:0] w);
    bus.fp_data  = w;
    bus.fp_valid = 1'b1;
    @(negedge clk);
    bus.fp_valid = 1'b0;
  endtask

  task automatic pulse_done();
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (bus.busy && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_stream(input string tag);
    logic [31:0] got;
    check({tag, "_len"}, 32'(cap_q.size()), 32'(4 * exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = 'x;
      if (4 * i + 3 < cap_q.size())
        got = {cap_q[4*i], cap_q[4*i+1], cap_q[4*i+2], cap_q[4*i+3]};
      check($sformatf("%s_word%0d", tag, i), got, exp_q[i]);
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [31:0] pattern(input int i, input logic [7:0] salt);
    logic [7:0] b;
    b = 8'(i);
    return {b, salt ^ b, ~b, 8'(b * 8'd3)};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prevb;
    int n;
    bus.fp_valid  = 1'b0;
    bus.fp_data   = '0;
    lbus.fp_valid = 1'b0;
    lbus.fp_data  = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_data", 32'(bus.uart_tx_data), 32'd0);
    check("rst_send", 32'(bus.uart_send_data), 32'd0);
    check("rst_words", 32'(bus.words_sent), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.fp_ready), 32'd1);

    // 1) Single word MSB first, done 5 cycles after each strobe
    resp_en = 1'b1;
    push(32'h3F800000);
    check("t1_lat_e0_send", 32'(bus.uart_send_data), 32'd0);
    @(negedge clk);
    check("t1_lat_e1_send", 32'(bus.uart_send_data), 32'd1);
    check("t1_first_byte", 32'(bus.uart_tx_data), 32'h3F);
    n = 0;
    prevb = 1'b0;
    while (bus.words_sent != 16'd1 && n < 200) begin
      prevb = bus.busy;
      @(negedge clk);
      n++;
    end
    check("t1_words", 32'(bus.words_sent), 32'd1);
    check("t1_busy_fall", 32'(bus.busy), 32'd0);
    check("t1_busy_before", 32'(prevb), 32'd1);
    exp_q.push_back(32'h3F800000);
    check_stream("t1");

    // 2) LSB-first instance
    lbus.fp_data  = 32'hC1200000;
    lbus.fp_valid = 1'b1;
    @(negedge clk);
    lbus.fp_valid = 1'b0;
    n = 0;
    while (lbus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t2_len", 32'(lcap_q.size()), 32'd4);
    if (lcap_q.size() >= 4)
      check("t2_bytes", {lcap_q[0], lcap_q[1], lcap_q[2], lcap_q[3]}, 32'h000020C1);
    check("t2_words", 32'(lbus.words_sent), 32'd1);

    // 3) Fill with no dones, overflow, then drain in order
    resp_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      check($sformatf("t3_ready%0d", i), 32'(bus.fp_ready), 32'd1);
      push(pattern(i, 8'hA5));
      exp_q.push_back(pattern(i, 8'hA5));
    end
    check("t3_full", 32'(bus.fp_ready), 32'd0);
    check("t3_no_ovf_yet", 32'(bus.overflow), 32'd0);
    push(32'hDEADBEEF);
    check("t3_overflow", 32'(bus.overflow), 32'd1);
    resp_en = 1'b1;
    pulse_done();
    wait_idle("t3_drain", 3000);
    check_stream("t3");
    check("t3_words", 32'(bus.words_sent), 32'd18);
    check("t3_ovf_sticky", 32'(bus.overflow), 32'd1);

    // 4) Push while full in the same cycle the FSM pops
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("t4_ovf_cleared", 32'(bus.overflow), 32'd0);
    check("t4_words_cleared", 32'(bus.words_sent), 32'd0);
    resp_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      push(pattern(i, 8'h3C));
      exp_q.push_back(pattern(i, 8'h3C));
    end
    check("t4_full", 32'(bus.fp_ready), 32'd0);
    for (int b = 0; b < 4; b++) begin
      pulse_done();
      if (b < 3) repeat (3) @(negedge clk);
    end
    bus.fp_data  = 32'hBAD0BAD0;
    bus.fp_valid = 1'b1;
    resp_en      = 1'b1;
    check("t4_full_at_pop", 32'(bus.fp_ready), 32'd0);
    @(negedge clk);
    bus.fp_valid = 1'b0;
    check("t4_overflow", 32'(bus.overflow), 32'd1);
    check("t4_ready_after_pop", 32'(bus.fp_ready), 32'd1);
    check("t4_pop_strobe", 32'(bus.uart_send_data), 32'd1);
    wait_idle("t4_drain", 3000);
    check_stream("t4");
    check("t4_words", 32'(bus.words_sent), 32'd17);

    // 5) Spurious done in IDLE and in SEND
    resp_en = 1'b0;
    pulse_done();
    repeat (3) @(negedge clk);
    check("t5_idle_no_strobe", 32'(cap_q.size()), 32'd0);
    check("t5_idle_busy", 32'(bus.busy), 32'd0);
    push(32'hA1B2C3D4);
    @(negedge clk);
    check("t5_send", 32'(bus.uart_send_data), 32'd1);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    check("t5_after_send", 32'(bus.uart_send_data), 32'd0);
    check("t5_hold_byte", 32'(bus.uart_tx_data), 32'hA1);
    for (int b = 0; b < 4; b++) begin
      repeat (2) @(negedge clk);
      pulse_done();
    end
    wait_idle("t5_drain", 100);
    exp_q.push_back(32'hA1B2C3D4);
    check_stream("t5");
    check("t5_words", 32'(bus.words_sent), 32'd18);

    // 6) Reset after the 2nd byte with 3 words queued
    for (int i = 0; i < 4; i++) push(pattern(i, 8'h77));
    pulse_done();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_tx_data", 32'(bus.uart_tx_data), 32'd0);
    check("t6_send", 32'(bus.uart_send_data), 32'd0);
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_words", 32'(bus.words_sent), 32'd0);
    check("t6_overflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cap_q.delete();
    repeat (20) @(negedge clk);
    check("t6_no_strobe", 32'(cap_q.size()), 32'd0);
    check("t6_idle", 32'(bus.busy), 32'd0);
    check("t6_ready", 32'(bus.fp_ready), 32'd1);
    push(32'h55AA00FF);
    @(negedge clk);
    check("t6_restart_send", 32'(bus.uart_send_data), 32'd1);
    check("t6_restart_byte", 32'(bus.uart_tx_data), 32'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
